// File: rtl/axi_arbiter_pkg.sv
// Shared types and helpers for the AXI manager arbiter: FSM states,
// AXI burst/response encodings and the response-status check.
package axi_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_RESP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    function automatic logic is_resp_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant
// and the first asserted request wins.
module rr_arbiter #(
    parameter int NumRequesters = 4,
    parameter int IdxWidth      = $clog2(NumRequesters)
) (
    input  logic [NumRequesters-1:0] req,
    input  logic [IdxWidth-1:0]      last_grant,
    input  logic                     en,
    output logic [NumRequesters-1:0] grant,
    output logic [IdxWidth-1:0]      grant_idx
);

    logic                found;
    logic [IdxWidth-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (en) begin
            for (int i = 1; i <= NumRequesters; i++) begin
                cand = IdxWidth'((int'(last_grant) + i) % NumRequesters);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/axi_manager_arbiter.sv
// Shares one AXI4 manager port between NumRequesters single-beat clients,
// one transaction outstanding at a time, round-robin granted.
module axi_manager_arbiter
    import axi_arbiter_pkg::*;
#(
    parameter int NumRequesters = 4,
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int IdWidth       = 4
) (
    input  logic                                       aclk,
    input  logic                                       areset,
    input  logic [NumRequesters-1:0]                   req_valid,
    output logic [NumRequesters-1:0]                   req_ready,
    input  logic [NumRequesters-1:0]                   req_write,
    input  logic [NumRequesters-1:0][AddressWidth-1:0] req_addr,
    input  logic [NumRequesters-1:0][2:0]              req_size,
    input  logic [NumRequesters-1:0][DataWidth-1:0]    req_wdata,
    input  logic [NumRequesters-1:0][DataWidth/8-1:0]  req_wstrb,
    output logic [NumRequesters-1:0]                   rsp_valid,
    output logic [DataWidth-1:0]                       rsp_rdata,
    output logic                                       rsp_error,
    output logic                                       awvalid,
    input  logic                                       awready,
    output logic [IdWidth-1:0]                         awid,
    output logic [AddressWidth-1:0]                    awaddr,
    output logic [7:0]                                 awlen,
    output logic [2:0]                                 awsize,
    output logic [1:0]                                 awburst,
    output logic                                       awlock,
    output logic [2:0]                                 awprot,
    output logic                                       wvalid,
    input  logic                                       wready,
    output logic [DataWidth-1:0]                       wdata,
    output logic [DataWidth/8-1:0]                     wstrb,
    output logic                                       wlast,
    input  logic                                       bvalid,
    output logic                                       bready,
    input  logic [IdWidth-1:0]                         bid,
    input  logic [1:0]                                 bresp,
    output logic                                       arvalid,
    input  logic                                       arready,
    output logic [IdWidth-1:0]                         arid,
    output logic [AddressWidth-1:0]                    araddr,
    output logic [7:0]                                 arlen,
    output logic [2:0]                                 arsize,
    output logic [1:0]                                 arburst,
    output logic                                       arlock,
    output logic [2:0]                                 arprot,
    input  logic                                       rvalid,
    output logic                                       rready,
    input  logic [IdWidth-1:0]                         rid,
    input  logic [DataWidth-1:0]                       rdata,
    input  logic [1:0]                                 rresp,
    input  logic                                       rlast
);

    localparam int IdxWidth = $clog2(NumRequesters);

    state_e                  state_q, state_d;
    logic [IdxWidth-1:0]     last_grant_q, g_q, grant_idx;
    logic [NumRequesters-1:0] grant;
    logic                    accept;
    logic [AddressWidth-1:0] addr_q;
    logic [2:0]              size_q;
    logic [DataWidth-1:0]    wdata_q, rsp_rdata_d;
    logic [DataWidth/8-1:0]  wstrb_q;
    logic                    awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
    logic                    rsp_error_d;

    rr_arbiter #(.NumRequesters(NumRequesters), .IdxWidth(IdxWidth)) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .en         ((state_q == IDLE) && !areset),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign accept    = |grant;
    assign req_ready = grant;
    assign rsp_valid = (state_q == DONE) ? (NumRequesters'(1) << g_q) : '0;

    assign awid    = IdWidth'(g_q);
    assign arid    = IdWidth'(g_q);
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awsize  = size_q;
    assign arsize  = size_q;
    assign awlen   = '0;
    assign arlen   = '0;
    assign awburst = BURST_INCR;
    assign arburst = BURST_INCR;
    assign awlock  = 1'b0;
    assign arlock  = 1'b0;
    assign awprot  = '0;
    assign arprot  = '0;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        arvalid_d   = arvalid;
        bready_d    = bready;
        rready_d    = rready;
        rsp_rdata_d = rsp_rdata;
        rsp_error_d = rsp_error;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    awvalid_d = req_write[grant_idx];
                    wvalid_d  = req_write[grant_idx];
                    arvalid_d = !req_write[grant_idx];
                    state_d   = req_write[grant_idx] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; move on once neither is pending.
                awvalid_d = awvalid && !awready;
                wvalid_d  = wvalid && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_d    = 1'b0;
                    rsp_error_d = (bid != IdWidth'(g_q)) || !is_resp_ok(bresp);
                    state_d     = DONE;
                end
            end
            RD_RESP: begin
                if (rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_error_d = (rid != IdWidth'(g_q)) || !is_resp_ok(rresp) || !rlast;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            last_grant_q <= IdxWidth'(NumRequesters - 1);
            g_q          <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            arvalid      <= 1'b0;
            bready       <= 1'b0;
            rready       <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            arvalid   <= arvalid_d;
            bready    <= bready_d;
            rready    <= rready_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_error <= rsp_error_d;
            if (accept) begin
                last_grant_q <= grant_idx;
                g_q          <= grant_idx;
                addr_q       <= req_addr[grant_idx];
                size_q       <= req_size[grant_idx];
                wdata_q      <= req_wdata[grant_idx];
                wstrb_q      <= req_wstrb[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_axi_manager_arbiter.sv
// Directed bench for axi_manager_arbiter with a hand-driven AXI subordinate.
module tb_axi_manager_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic aclk = 1'b0;
    logic areset;
    logic [N-1:0]          req_valid, req_ready, req_write, rsp_valid;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0][2:0]     req_size;
    logic [N-1:0][DW-1:0]  req_wdata;
    logic [N-1:0][DW/8-1:0] req_wstrb;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_error;
    logic                  awvalid, awready, awlock, wvalid, wready, wlast;
    logic [IW-1:0]         awid, arid, bid, rid;
    logic [AW-1:0]         awaddr, araddr;
    logic [7:0]            awlen, arlen;
    logic [2:0]            awsize, arsize, awprot, arprot;
    logic [1:0]            awburst, arburst, bresp, rresp;
    logic [DW-1:0]         wdata, rdata;
    logic [DW/8-1:0]       wstrb;
    logic                  bvalid, bready, arvalid, arready, arlock, rvalid, rready, rlast;

    int checks = 0;
    int errors = 0;

    axi_manager_arbiter #(.NumRequesters(N), .AddressWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_size = '0;
        req_wdata = '0; req_wstrb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;

        // Reset state, with every client requesting
        req_valid = 4'b1111;
        tick(); tick(); #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_rsp", {rsp_error, rsp_rdata}, 33'h0);
        chk("rst_payload", {awid, awaddr, wdata, wstrb}, 72'h0);

        // Single write, client 1
        tick();
        areset = 1'b0;
        req_valid = 4'b0010; req_write = 4'b0010;
        req_addr[1] = 32'h10; req_wdata[1] = 32'hDEADBEEF; req_wstrb[1] = 4'hF; req_size[1] = 3'd2;
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("wr1_req_ready", req_ready, 4'b0010);
        tick(); req_valid = '0; #1;
        chk("wr1_aw_w_valid", {awvalid, wvalid, arvalid}, 3'b110);
        chk("wr1_awid", awid, 4'd1);
        chk("wr1_awaddr", awaddr, 32'h10);
        chk("wr1_wdata", wdata, 32'hDEADBEEF);
        chk("wr1_fixed", {wlast, awlen, awburst, awsize, wstrb}, {1'b1, 8'd0, 2'b01, 3'd2, 4'hF});
        chk("wr1_req_ready_pulse", req_ready, 4'b0000);
        tick();
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        #1;
        chk("wr1_t2", {awvalid, wvalid, bready}, 3'b001);
        tick(); bvalid = 1'b0; #1;
        chk("wr1_rsp_valid", rsp_valid, 4'b0010);
        chk("wr1_rsp_error", rsp_error, 1'b0);
        chk("wr1_bready_drop", bready, 1'b0);
        tick(); #1;
        chk("wr1_rsp_one_cycle", rsp_valid, 4'b0000);

        // Skewed handshakes: W done at T+1, AW at T+4, B one cycle late
        req_valid = 4'b1000; req_write = 4'b1000;
        req_addr[3] = 32'h20; req_wdata[3] = 32'hA5A50001; req_wstrb[3] = 4'h3; req_size[3] = 3'd2;
        awready = 1'b0; wready = 1'b1;
        #1;
        chk("skew_req_ready", req_ready, 4'b1000);
        tick(); req_valid = '0; #1;
        chk("skew_t1", {awvalid, wvalid}, 2'b11);
        chk("skew_awid", awid, 4'd3);
        tick(); wready = 1'b0; #1;
        chk("skew_t2", {awvalid, wvalid, bready}, 3'b100);
        tick(); #1;
        chk("skew_t3", {awvalid, wvalid, bready}, 3'b100);
        tick(); awready = 1'b1; #1;
        chk("skew_t4", {awvalid, wvalid, bready}, 3'b100);
        chk("skew_wstrb_hold", wstrb, 4'h3);
        tick(); awready = 1'b0; #1;
        chk("skew_t5", {awvalid, wvalid, bready}, 3'b001);
        tick(); bvalid = 1'b1; bid = 4'd3; bresp = 2'b01; #1;
        chk("skew_b_wait", {bready, rsp_valid}, 5'b10000);
        tick(); bvalid = 1'b0; #1;
        chk("skew_rsp", {rsp_valid, rsp_error}, 5'b1000_0);
        tick(); #1;
        chk("skew_single_rsp", {rsp_valid, bready}, 5'b0);

        // Read with SLVERR, client 2
        req_valid = 4'b0100; req_write = 4'b0000;
        req_addr[2] = 32'h40; req_size[2] = 3'd2;
        arready = 1'b1;
        #1;
        chk("rd_req_ready", req_ready, 4'b0100);
        tick(); req_valid = '0; #1;
        chk("rd_arvalid", {arvalid, awvalid, wvalid}, 3'b100);
        chk("rd_ar_fields", {arid, araddr, arlen, arburst}, {4'd2, 32'h40, 8'd0, 2'b01});
        tick();
        rvalid = 1'b1; rid = 4'd2; rdata = 32'h1234; rresp = 2'b10; rlast = 1'b1;
        #1;
        chk("rd_t2", {arvalid, rready}, 2'b01);
        tick(); rvalid = 1'b0; #1;
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rsp_error", rsp_error, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h1234);
        tick(); #1;

        // ID mismatch on a client-0 write with zero strobe
        req_valid = 4'b0001; req_write = 4'b0001;
        req_addr[0] = 32'h0; req_wdata[0] = 32'h11223344; req_wstrb[0] = 4'h0; req_size[0] = 3'd2;
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("idm_req_ready", req_ready, 4'b0001);
        tick(); req_valid = '0; #1;
        chk("idm_zero_strb_issued", {awvalid, wvalid, wstrb}, 6'b11_0000);
        tick(); bvalid = 1'b1; bid = 4'd3; bresp = 2'b00; #1;
        chk("idm_bready", bready, 1'b1);
        tick(); bvalid = 1'b0; #1;
        chk("idm_rsp", {rsp_valid, rsp_error}, 5'b0001_1);
        tick(); #1;

        // Reset while waiting in WR_RESP (client 2 write)
        req_valid = 4'b0100; req_write = 4'b0100;
        req_addr[2] = 32'h80; req_wdata[2] = 32'hCAFEF00D; req_wstrb[2] = 4'hF;
        #1;
        chk("rstmid_req_ready", req_ready, 4'b0100);
        tick(); req_valid = '0; #1;
        chk("rstmid_awvalid", awvalid, 1'b1);
        tick(); #1;
        chk("rstmid_bready", bready, 1'b1);
        areset = 1'b1; req_valid = 4'b1111; req_write = '0;
        #1;
        chk("rstmid_cleared", {awvalid, wvalid, arvalid, bready, rready, rsp_error}, 6'b0);
        chk("rstmid_payload", {awid, awaddr, wdata}, 68'h0);
        chk("rstmid_no_ready", {req_ready, rsp_valid}, 8'h00);
        tick(); #1;
        chk("rstmid_no_rsp", rsp_valid, 4'b0000);

        // Contention from reset: all clients read, grant order 0,1,2,3,0
        for (int i = 0; i < N; i++) begin
            req_addr[i] = 32'h1000 + 32'(i * 4);
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b1;
        tick(); areset = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            int g;
            g = k % N;
            oh = 4'b0001 << g;
            chk($sformatf("cont%0d_req_ready", k), req_ready, oh);
            tick(); #1;
            chk($sformatf("cont%0d_ar", k), {arvalid, arid, araddr}, {1'b1, 4'(g), 32'h1000 + 32'(g * 4)});
            tick();
            rvalid = 1'b1; rid = 4'(g); rdata = 32'h100 + 32'(k); rresp = 2'b00; rlast = 1'b1;
            #1;
            chk($sformatf("cont%0d_rready", k), rready, 1'b1);
            tick(); rvalid = 1'b0; #1;
            chk($sformatf("cont%0d_rsp", k), {rsp_valid, rsp_error, rsp_rdata}, {oh, 1'b0, 32'h100 + 32'(k)});
            tick(); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_manager_arbiter.md
# axi_manager_arbiter

Round-robin arbiter that shares one AXI4 manager port between `NumRequesters` simple single-beat request/response clients. It accepts one request at a time, drives the AW/W/B or AR/R channel sequence for one beat, and returns the response to the granted requester. It sits between the bus-connection front-ends and the AXI subordinate, replacing direct per-client AXI sequencing.

## Interface
- `NumRequesters`, 4: number of clients, 2..16.
- `AddressWidth`, 32: AXI address width.
- `DataWidth`, 32: AXI data width, 8..1024, power of two; `StrobeWidth = DataWidth/8`.
- `IdWidth`, 4: AXI ID width, ≥ clog2(`NumRequesters`).
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NumRequesters`  per-client request pending.
- `req_ready`  out  `NumRequesters`  one-hot accept pulse.
- `req_write`  in  `NumRequesters`  1 = write, 0 = read.
- `req_addr`  in  `NumRequesters`×`AddressWidth`  byte address.
- `req_size`  in  `NumRequesters`×3  AXI size encoding.
- `req_wdata` / `req_wstrb`  in  `NumRequesters`×`DataWidth` / ×`StrobeWidth`  lane-aligned write data and strobe.
- `rsp_valid`  out  `NumRequesters`  one-hot response pulse.
- `rsp_rdata`  out  `DataWidth`  read data; shared; valid with `rsp_valid`.
- `rsp_error`  out  1  response error; shared; valid with `rsp_valid`.
- `awvalid`/`awready`, `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awprot`: AW channel, manager side.
- `wvalid`/`wready`, `wdata`, `wstrb`, `wlast`: W channel, manager side.
- `bvalid`/`bready`, `bid`, `bresp`: B channel.
- `arvalid`/`arready`, `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arprot`: AR channel.
- `rvalid`/`rready`, `rid`, `rdata`, `rresp`, `rlast`: R channel.

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_RESP, DONE.
- IDLE, arbitration:
  - Round-robin search starts at `last_grant+1` mod N; the first set `req_valid` wins.
  - `req_ready[g]` is asserted combinationally for that cycle only.
  - Request fields are latched into registers.
  - `last_grant` is updated to `g`.
  - Next state is WR_ADDR_DATA if `req_write`, else RD_ADDR.
- Transaction ID: `awid`/`arid = g`, zero-extended to `IdWidth`.
- Fixed AXI fields: `awlen`/`arlen = 0`, `awburst`/`arburst = INCR (2'b01)`, `lock = 0`, `prot = 0`, `wlast = 1`.
- WR_ADDR_DATA:
  - `awvalid` and `wvalid` rise together.
  - Each valid drops independently after its own handshake.
  - When both handshakes are done, the FSM goes to WR_RESP with `bready = 1`.
- RD_ADDR: `arvalid = 1` until `arready`; then RD_RESP with `rready = 1`.
- WR_RESP / RD_RESP:
  - On the `bvalid`/`rvalid` handshake, the block captures `rdata` (reads), computes error, and drops ready.
  - Next state is DONE.
- Error is set when any of the following holds:
  - response ID ≠ `g`;
  - resp ∉ {OKAY 2'b00, EXOKAY 2'b01};
  - read with `rlast = 0`.
- DONE: `rsp_valid[g] = 1` for one cycle with registered `rsp_rdata`/`rsp_error`; the FSM then returns to IDLE.
- Data and strobe are passed through unmodified; lane alignment is the requester's job.
- A write with `req_wstrb == 0` is still issued.
- Only one transaction is outstanding at a time; no reordering is possible.

## Timing
- Reset values: every valid, ready, `req_ready` and `rsp_valid` output is 0. `rsp_rdata`/`rsp_error` and all AXI payload outputs are 0. FSM is IDLE and `last_grant = NumRequesters-1`, so client 0 wins first.
- AXI valids and readies are registered outputs. Valids never depend combinationally on ready.
- Minimum write latency, with accept at cycle T:
  - `awvalid`/`wvalid` at T+1; both handshakes at T+1.
  - `bready` at T+2; `bvalid` at T+2.
  - `rsp_valid` at T+3.
- Reads follow the same latency as writes.
- AW and W handshakes in different cycles are both waited for, in either order.
- After `rsp_valid`, earliest next accept is the following cycle, so there is ≥1 idle bus cycle between transactions.
- Payloads are held stable from valid until handshake. Late responses are simply waited for; there is no timeout.
- `areset` mid-transaction: immediate return to reset values, and the in-flight request is dropped with no `rsp_valid`. The requester reissues; the subordinate is reset alongside.

## Structure
- Shared package `axi_arbiter_pkg` holds:
  - the `state_e` enum;
  - `burst_e` (FIXED/INCR/WRAP);
  - `resp_e` (OKAY/EXOKAY/SLVERR/DECERR);
  - the `is_resp_ok()` function.
- Sub-module `rr_arbiter`:
  - parameterised by `NumRequesters`;
  - inputs: request vector, `last_grant`, enable;
  - outputs: one-hot grant and encoded index;
  - purely combinational.

## Test plan
- Single write: client 1 writes `0x10`←`0xDEADBEEF`, strobe `4'hF`, subordinate ready at once. Expect `awid=1`, `wlast=1`, `rsp_valid[1]` at T+3, `rsp_error=0`.
- Contention: all 4 clients hold `req_valid` from reset. Expect grant order 0,1,2,3,0, with no client served twice before all are served.
- Skewed handshakes: `wready` 3 cycles before `awready`. Expect `wvalid` to drop after its handshake, `awvalid` to hold, and one B wait only.
- Read error: client 2 reads `0x40`, subordinate returns `rresp=SLVERR`, `rdata=0x1234`. Expect `rsp_valid[2]`, `rsp_error=1`, `rsp_rdata=0x1234`.
- ID mismatch: `bid=3` for a client-0 write. Expect `rsp_error=1`.
- Reset in WR_RESP: assert `areset` with `bready=1`. Expect all outputs 0 immediately, no `rsp_valid`, and client 0 granted first after release.
